// File: rtl/tlk2711_rd_arb.sv
// Round-robin read-command arbiter for NUM_CH tx channels in front of one DMA read port.
// An owner FIFO records which channel each issued command belongs to, so returned bursts go back to that channel.
module tlk2711_rd_arb #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 48,
  parameter int DLEN_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      i_soft_rst,
  input  logic [NUM_CH-1:0]                         i_ch_en,
  input  logic [NUM_CH-1:0]                         i_ch_cmd_req,
  input  logic [NUM_CH*(DLEN_WIDTH+ADDR_WIDTH)-1:0] i_ch_cmd_data,
  output logic [NUM_CH-1:0]                         o_ch_cmd_ack,
  output logic                                      o_rd_cmd_req,
  output logic [DLEN_WIDTH+ADDR_WIDTH-1:0]          o_rd_cmd_data,
  input  logic                                      i_rd_cmd_ack,
  input  logic                                      i_dma_rd_valid,
  input  logic                                      i_dma_rd_last,
  input  logic [DATA_WIDTH-1:0]                     i_dma_rd_data,
  output logic                                      o_dma_rd_ready,
  output logic [NUM_CH-1:0]                         o_ch_rd_valid,
  output logic [NUM_CH-1:0]                         o_ch_rd_last,
  output logic [DATA_WIDTH-1:0]                     o_ch_rd_data,
  input  logic [NUM_CH-1:0]                         i_ch_rd_ready,
  output logic [$clog2(OUT_DEPTH):0]                o_outstanding
);

  localparam int CMD_W = DLEN_WIDTH + ADDR_WIDTH;
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_IDLE,
    ST_REQ
  } state_t;

  state_t            state_reg, state_next;
  logic [CH_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [CH_W-1:0]   gnt_id_reg, gnt_id_next;
  logic              cmd_req_reg, cmd_req_next;
  logic [CMD_W-1:0]  cmd_data_reg, cmd_data_next;

  logic [CH_W-1:0]   owner_mem [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  logic              flush;
  logic [NUM_CH-1:0] eligible;
  logic              pick_valid;
  logic [CH_W-1:0]   pick_id;
  logic [NUM_CH-1:0] ack_vec;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CH_W-1:0]   owner;

  assign flush      = rst | i_soft_rst;
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNT_W'(OUT_DEPTH));
  assign owner      = owner_mem[rd_ptr_reg];

  // Channel index 'offset' places after 'base', wrapping at NUM_CH (which need not be a power of 2).
  function automatic logic [CH_W-1:0] ch_index(input logic [CH_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_CH) sum = sum - NUM_CH;
    return CH_W'(sum);
  endfunction

  // Round-robin search starting at rr_ptr.
  always_comb begin
    eligible   = i_ch_cmd_req & i_ch_en;
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!pick_valid && eligible[ch_index(rr_ptr_reg, k)]) begin
        pick_valid = 1'b1;
        pick_id    = ch_index(rr_ptr_reg, k);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    gnt_id_next   = gnt_id_reg;
    cmd_req_next  = cmd_req_reg;
    cmd_data_next = cmd_data_reg;
    push          = 1'b0;
    ack_vec       = '0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_full && pick_valid) begin
          state_next    = ST_REQ;
          gnt_id_next   = pick_id;
          cmd_req_next  = 1'b1;
          cmd_data_next = i_ch_cmd_data[int'(pick_id)*CMD_W +: CMD_W];
        end
      end
      ST_REQ: begin
        // Once issued, the command completes even if the channel drops its request.
        if (i_rd_cmd_ack) begin
          push                = 1'b1;
          ack_vec[gnt_id_reg] = 1'b1;
          rr_ptr_next         = (gnt_id_reg == CH_W'(NUM_CH - 1)) ? '0 : gnt_id_reg + 1'b1;
          cmd_req_next        = 1'b0;
          state_next          = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state_reg    <= ST_IDLE;
      rr_ptr_reg   <= '0;
      gnt_id_reg   <= '0;
      cmd_req_reg  <= 1'b0;
      cmd_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      gnt_id_reg   <= gnt_id_next;
      cmd_req_reg  <= cmd_req_next;
      cmd_data_reg <= cmd_data_next;
    end
  end

  assign pop = i_dma_rd_valid & o_dma_rd_ready & i_dma_rd_last;

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) owner_mem[wr_ptr_reg] <= gnt_id_reg;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Beats arriving with no owner are held off rather than dropped.
  assign o_dma_rd_ready = !fifo_empty && i_ch_rd_ready[owner];
  assign o_ch_rd_data   = fifo_empty ? '0 : i_dma_rd_data;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_route
      assign o_ch_rd_valid[gi] = !fifo_empty && (owner == CH_W'(gi)) && i_dma_rd_valid;
      assign o_ch_rd_last[gi]  = !fifo_empty && (owner == CH_W'(gi)) && i_dma_rd_last;
    end
  endgenerate

  assign o_ch_cmd_ack  = ack_vec;
  assign o_rd_cmd_req  = cmd_req_reg;
  assign o_rd_cmd_data = cmd_data_reg;
  assign o_outstanding = count_reg;

endmodule

// File: tb/tb_tlk2711_rd_arb.sv
// Bench for tlk2711_rd_arb: grant-order vector table plus hand sequences for bursts, back-pressure, flush and FIFO full.
module tb_tlk2711_rd_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_soft_rst;
  logic [3:0]   i_ch_en;
  logic [3:0]   i_ch_cmd_req;
  logic [255:0] i_ch_cmd_data;
  logic [3:0]   o_ch_cmd_ack;
  logic         o_rd_cmd_req;
  logic [63:0]  o_rd_cmd_data;
  logic         i_rd_cmd_ack;
  logic         i_dma_rd_valid;
  logic         i_dma_rd_last;
  logic [63:0]  i_dma_rd_data;
  logic         o_dma_rd_ready;
  logic [3:0]   o_ch_rd_valid;
  logic [3:0]   o_ch_rd_last;
  logic [63:0]  o_ch_rd_data;
  logic [3:0]   i_ch_rd_ready;
  logic [2:0]   o_outstanding;

  tlk2711_rd_arb dut (
    .clk(clk), .rst(rst), .i_soft_rst(i_soft_rst),
    .i_ch_en(i_ch_en), .i_ch_cmd_req(i_ch_cmd_req), .i_ch_cmd_data(i_ch_cmd_data),
    .o_ch_cmd_ack(o_ch_cmd_ack), .o_rd_cmd_req(o_rd_cmd_req), .o_rd_cmd_data(o_rd_cmd_data),
    .i_rd_cmd_ack(i_rd_cmd_ack), .i_dma_rd_valid(i_dma_rd_valid), .i_dma_rd_last(i_dma_rd_last),
    .i_dma_rd_data(i_dma_rd_data), .o_dma_rd_ready(o_dma_rd_ready), .o_ch_rd_valid(o_ch_rd_valid),
    .o_ch_rd_last(o_ch_rd_last), .o_ch_rd_data(o_ch_rd_data), .i_ch_rd_ready(i_ch_rd_ready),
    .o_outstanding(o_outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] en;
    int         exp_ch;
    bit         exp_grant;
  } vec_t;

  typedef struct {
    int          ch;
    logic [63:0] data;
    logic        last;
  } beat_t;

  int          total = 0;
  int          bad = 0;
  logic [63:0] ch_word [4];
  vec_t        vecs [12];
  beat_t       sb_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted beat must match the oldest expected beat.
  always @(negedge clk) begin
    beat_t e;
    if (i_dma_rd_valid && o_dma_rd_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL beat_unexpected: got data %h expected no beat", i_dma_rd_data);
      end else begin
        e = sb_q.pop_front();
        check("beat_valid", 64'(o_ch_rd_valid), 64'(4'b0001 << e.ch));
        check("beat_last",  64'(o_ch_rd_last),  e.last ? 64'(4'b0001 << e.ch) : 64'h0);
        check("beat_data",  o_ch_rd_data, e.data);
      end
    end
  end

  task automatic drive_beat(input int ch, input logic last);
    beat_t e;
    e.ch   = ch;
    e.data = {$urandom, $urandom};
    e.last = last;
    i_dma_rd_valid = 1'b1;
    i_dma_rd_last  = last;
    i_dma_rd_data  = e.data;
    sb_q.push_back(e);
  endtask

  task automatic send_burst(input int n, input int ch);
    int waited;
    for (int b = 0; b < n; b++) begin
      drive_beat(ch, b == n - 1);
      #1;
      waited = 0;
      while (!o_dma_rd_ready && waited < 10) begin
        step();
        waited++;
      end
      if (!o_dma_rd_ready) check("burst_ready_timeout", 64'(o_dma_rd_ready), 64'h1);
      step();
    end
    i_dma_rd_valid = 1'b0;
    i_dma_rd_last  = 1'b0;
    #1;
  endtask

  task automatic do_grant(input logic [3:0] req, input logic [3:0] en, input int exp_ch, input bit exp_grant);
    bit got;
    i_ch_cmd_req = req;
    i_ch_en      = en;
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      step();
      if (o_rd_cmd_req) got = 1'b1;
    end
    if (!exp_grant) begin
      check("no_grant", 64'(got), 64'h0);
      i_ch_cmd_req = '0;
      return;
    end
    check("grant_req", 64'(got), 64'h1);
    if (!got) return;
    check("cmd_data", o_rd_cmd_data, ch_word[exp_ch]);
    step();
    check("req_hold", 64'(o_rd_cmd_req), 64'h1);
    i_rd_cmd_ack = 1'b1;
    #1;
    check("cmd_ack", 64'(o_ch_cmd_ack), 64'(4'b0001 << exp_ch));
    step();
    i_rd_cmd_ack = 1'b0;
    i_ch_cmd_req = '0;
    #1;
    check("ack_pulse", 64'(o_ch_cmd_ack), 64'h0);
    check("req_drop", 64'(o_rd_cmd_req), 64'h0);
  endtask

  task automatic pulse_soft_rst();
    i_soft_rst = 1'b1;
    step();
    i_soft_rst = 1'b0;
    #1;
  endtask

  initial begin
    int acks;
    int ack_ids [$];
    bit got;

    ch_word[0] = {16'h0040, 48'h0000_1000_0000};
    ch_word[1] = {16'h0080, 48'h0000_4000_0000};
    ch_word[2] = {16'h0100, 48'h0000_8000_0000};
    ch_word[3] = {16'h0200, 48'h0000_C000_0000};
    // Expected grants, rr_ptr carried across rows (starts at 0 after reset).
    vecs[0]  = '{4'hF, 4'hF, 0, 1'b1};
    vecs[1]  = '{4'hF, 4'hF, 1, 1'b1};
    vecs[2]  = '{4'hF, 4'hF, 2, 1'b1};
    vecs[3]  = '{4'hF, 4'hF, 3, 1'b1};
    vecs[4]  = '{4'hF, 4'hF, 0, 1'b1};
    vecs[5]  = '{4'h4, 4'hF, 2, 1'b1};
    vecs[6]  = '{4'h4, 4'hF, 2, 1'b1};
    vecs[7]  = '{4'hF, 4'hA, 3, 1'b1};
    vecs[8]  = '{4'hF, 4'hA, 1, 1'b1};
    vecs[9]  = '{4'h1, 4'hE, 0, 1'b0};
    vecs[10] = '{4'h9, 4'hF, 3, 1'b1};
    vecs[11] = '{4'h9, 4'hF, 0, 1'b1};

    rst = 1'b1; i_soft_rst = 1'b0; i_ch_en = '0; i_ch_cmd_req = '0;
    i_ch_cmd_data = {ch_word[3], ch_word[2], ch_word[1], ch_word[0]};
    i_rd_cmd_ack = 1'b0; i_dma_rd_valid = 1'b0; i_dma_rd_last = 1'b0;
    i_dma_rd_data = '0; i_ch_rd_ready = 4'hF;
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("rst_req", 64'(o_rd_cmd_req), 64'h0);
    check("rst_data", o_rd_cmd_data, 64'h0);
    check("rst_outstanding", 64'(o_outstanding), 64'h0);
    check("rst_ack", 64'(o_ch_cmd_ack), 64'h0);

    // Data with no owner must be stalled.
    i_dma_rd_valid = 1'b1; i_dma_rd_last = 1'b1; i_dma_rd_data = 64'hDEAD_BEEF_0000_0001;
    #1;
    check("empty_ready", 64'(o_dma_rd_ready), 64'h0);
    check("empty_valid", 64'(o_ch_rd_valid), 64'h0);
    step();
    i_dma_rd_valid = 1'b0; i_dma_rd_last = 1'b0;
    #1;

    for (int v = 0; v < 12; v++) begin
      do_grant(vecs[v].req, vecs[v].en, vecs[v].exp_ch, vecs[v].exp_grant);
      if (vecs[v].exp_grant) begin
        check("vec_outstanding1", 64'(o_outstanding), 64'h1);
        send_burst(1, vecs[v].exp_ch);
        check("vec_outstanding0", 64'(o_outstanding), 64'h0);
      end
    end

    // Two grants then two bursts of different lengths (rr_ptr=1 here).
    do_grant(4'h2, 4'hF, 1, 1'b1);
    do_grant(4'h8, 4'hF, 3, 1'b1);
    check("two_outstanding", 64'(o_outstanding), 64'h2);
    send_burst(4, 1);
    check("after_burst4", 64'(o_outstanding), 64'h1);
    send_burst(2, 3);
    check("after_burst2", 64'(o_outstanding), 64'h0);

    // Back-pressure from the owner for 3 cycles mid-burst.
    do_grant(4'h1, 4'hF, 0, 1'b1);
    send_burst(1, 0);
    do_grant(4'h1, 4'hF, 0, 1'b1);
    drive_beat(0, 1'b0);
    step();
    drive_beat(0, 1'b0);
    i_ch_rd_ready = 4'hE;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_ready_low", 64'(o_dma_rd_ready), 64'h0);
      check("bp_valid_held", 64'(o_ch_rd_valid), 64'h1);
      step();
    end
    i_ch_rd_ready = 4'hF;
    step();
    send_burst(2, 0);
    check("bp_outstanding", 64'(o_outstanding), 64'h0);

    // Soft reset while a third command is pending.
    pulse_soft_rst();
    do_grant(4'h2, 4'hF, 1, 1'b1);
    do_grant(4'h4, 4'hF, 2, 1'b1);
    check("pre_flush_outstanding", 64'(o_outstanding), 64'h2);
    i_ch_cmd_req = 4'hF;
    step();
    check("pre_flush_req", 64'(o_rd_cmd_req), 64'h1);
    check("pre_flush_data", o_rd_cmd_data, ch_word[3]);
    pulse_soft_rst();
    check("flush_req", 64'(o_rd_cmd_req), 64'h0);
    check("flush_outstanding", 64'(o_outstanding), 64'h0);
    step();
    check("flush_rr_regrant", o_rd_cmd_data, ch_word[0]);
    i_ch_cmd_req = '0;
    pulse_soft_rst();

    // Fill the owner FIFO with requests held and the DMA acking immediately.
    i_ch_cmd_req = 4'hF; i_ch_en = 4'hF; i_rd_cmd_ack = 1'b1;
    acks = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      for (int b = 0; b < 4; b++) begin
        if (o_ch_cmd_ack[b]) begin
          acks++;
          ack_ids.push_back(b);
        end
      end
    end
    check("full_acks", 64'(acks), 64'h4);
    for (int i = 0; i < ack_ids.size() && i < 4; i++) check("full_order", 64'(ack_ids[i]), 64'(i));
    check("full_outstanding", 64'(o_outstanding), 64'h4);
    i_rd_cmd_ack = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (o_rd_cmd_req) got = 1'b1;
    end
    check("full_no_req", 64'(got), 64'h0);
    send_burst(1, 0);
    got = 1'b0;
    for (int c = 0; c < 3 && !got; c++) begin
      if (o_rd_cmd_req) got = 1'b1;
      else step();
    end
    check("refill_req", 64'(got), 64'h1);
    check("refill_data", o_rd_cmd_data, ch_word[0]);
    check("refill_outstanding", 64'(o_outstanding), 64'h3);
    check("sb_empty", 64'(sb_q.size()), 64'h0);

    i_ch_cmd_req = '0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
